// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed, XOR-checksummed byte image into the
//               instruction memory write port; holds the core until success.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_len0  = 3'd1;
    localparam logic [2:0] c_st_len1  = 3'd2;
    localparam logic [2:0] c_st_data  = 3'd3;
    localparam logic [2:0] c_st_check = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;
    localparam logic [2:0] c_st_err   = 3'd6;

    logic [2:0]          r_state;
    logic [15:0]         r_len;
    logic [ADDR_WIDTH:0] r_word_idx;
    logic [1:0]          r_lane;
    logic [7:0]          r_xor;
    logic [23:0]         r_shift;
    logic                r_wr_en;
    logic [31:0]         r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_error;

    logic                w_busy;
    logic [15:0]         w_len_full;
    logic [31:0]         w_len_ext;
    logic [ADDR_WIDTH:0] w_next_idx;
    logic                w_last_word;

    // Ready depends on registered state only, never on in_valid.
    assign w_busy      = (r_state == c_st_len0) || (r_state == c_st_len1) ||
                         (r_state == c_st_data) || (r_state == c_st_check);
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_len_ext   = {16'd0, w_len_full};
    assign w_next_idx  = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_last_word = (32'(w_next_idx) == {16'd0, r_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_lane     <= 2'd0;
            r_xor      <= 8'd0;
            r_shift    <= 24'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done, c_st_err: begin
                    if (start) begin
                        r_state    <= c_st_len0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_word_idx <= '0;
                        r_lane     <= 2'd0;
                        r_xor      <= 8'd0;
                    end
                end
                c_st_len0: begin
                    if (in_valid) begin
                        r_len[7:0] <= in_data;
                        r_xor      <= r_xor ^ in_data;
                        r_state    <= c_st_len1;
                    end
                end
                c_st_len1: begin
                    if (in_valid) begin
                        r_len[15:8] <= in_data;
                        r_xor       <= r_xor ^ in_data;
                        if (w_len_full == 16'd0) begin
                            r_state <= c_st_check;
                        end else if (w_len_ext > MAX_WORDS) begin
                            // Oversize image aborts before any checksum byte.
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (in_valid) begin
                        r_xor  <= r_xor ^ in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_shift[7:0]   <= in_data;
                            2'd1: r_shift[15:8]  <= in_data;
                            2'd2: r_shift[23:16] <= in_data;
                            default: begin
                                r_wr_en    <= 1'b1;
                                r_wr_data  <= {in_data, r_shift};
                                r_wr_addr  <= 32'(r_word_idx) << 2;
                                r_word_idx <= w_next_idx;
                                if (w_last_word) begin
                                    r_state <= c_st_check;
                                end
                            end
                        endcase
                    end
                end
                c_st_check: begin
                    if (in_valid) begin
                        if (in_data == r_xor) begin
                            r_state    <= c_st_done;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready = w_busy;
    assign busy     = w_busy;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed bench for imem_loader with a stream-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int unsigned c_max_words = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .ADDR_WIDTH(10),
        .MAX_WORDS (c_max_words)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs follow from the position of each accepted byte in the stream.
    bit          m_valid = 1'b0;
    bit          m_loading, m_done, m_err, m_hold, m_wr;
    int          m_k, m_n;
    logic [7:0]  m_x;
    logic [7:0]  m_b [4];
    logic [31:0] m_addr, m_data;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [7:0]  stream [$];

    initial begin
        int pos, lane;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("in_ready", 32'(in_ready), 32'(m_loading));
                chk("busy",     32'(busy),     32'(m_loading));
                chk("wr_en",    32'(wr_en),    32'(m_wr));
                chk("wr_addr",  wr_addr,       m_addr);
                chk("wr_data",  wr_data,       m_data);
                chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
                chk("done",     32'(done),     32'(m_done));
                chk("error",    32'(error),    32'(m_err));
            end
            if (wr_en === 1'b1) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
            end
            // Advance the model to what the next rising edge must produce.
            if (rst) begin
                m_valid = 1'b1; m_loading = 1'b0; m_k = 0; m_n = 0; m_x = 8'd0;
                m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1; m_wr = 1'b0;
                m_addr = 32'd0; m_data = 32'd0;
            end else if (m_valid) begin
                m_wr = 1'b0;
                if (!m_loading) begin
                    if (start) begin
                        m_loading = 1'b1; m_k = 0; m_n = 0; m_x = 8'd0;
                        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
                    end
                end else if (in_valid) begin
                    pos = m_k;
                    m_k++;
                    if (pos == 0) begin
                        m_n = int'(in_data);
                        m_x ^= in_data;
                    end else if (pos == 1) begin
                        m_n += int'(in_data) * 256;
                        m_x ^= in_data;
                        if (m_n > int'(c_max_words)) begin
                            m_loading = 1'b0;
                            m_err = 1'b1;
                        end
                    end else if (pos < 2 + 4 * m_n) begin
                        m_x ^= in_data;
                        lane = (pos - 2) % 4;
                        m_b[lane] = in_data;
                        if (lane == 3) begin
                            m_wr = 1'b1;
                            m_addr = 32'(((pos - 2) / 4) * 4);
                            m_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
                        end
                    end else begin
                        m_loading = 1'b0;
                        if (in_data == m_x) begin
                            m_done = 1'b1;
                            m_hold = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_accept();
        bit acc = 1'b0;
        int t = 0;
        while (!acc && t < 20) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready=1 at %0t", $time);
        end
    endtask

    task automatic send(input bit gaps, input int start_at);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 3));
                repeat (g) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            start    = (i == start_at);
            wait_accept();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic nominal_stream();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                   8'h93, 8'h05, 8'h10, 8'h00, 8'h32};
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic chk_result(input string tag, input bit exp_done, input bit exp_err, input int exp_writes);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".done"},     32'(done),     32'(exp_done));
        chk({tag, ".error"},    32'(error),    32'(exp_err));
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".writes"},   32'(log_addr.size()), 32'(exp_writes));
        if (exp_writes == 2 && log_addr.size() == 2) begin
            chk({tag, ".addr0"}, log_addr[0], 32'h0000_0000);
            chk({tag, ".data0"}, log_data[0], 32'h00A0_0513);
            chk({tag, ".addr1"}, log_addr[1], 32'h0000_0004);
            chk({tag, ".data1"}, log_data[1], 32'h0010_0593);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.cpu_hold", 32'(cpu_hold), 32'd1);
        chk("reset.done",     32'(done),     32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        chk("reset.wr_addr",  wr_addr,       32'd0);

        clear_log();
        pulse_start();
        nominal_stream();
        send(1'b0, -1);
        chk_result("nominal", 1'b1, 1'b0, 2);

        clear_log();
        pulse_start();
        nominal_stream();
        stream[10] = 8'h33;
        send(1'b0, -1);
        chk_result("badchk", 1'b0, 1'b1, 2);

        clear_log();
        pulse_start();
        stream = '{8'h00, 8'h00, 8'h00};
        send(1'b0, -1);
        chk_result("zero", 1'b1, 1'b0, 0);

        clear_log();
        pulse_start();
        stream = '{8'h01, 8'h04};
        send(1'b0, -1);
        chk("oversize.error_now", 32'(error),    32'd1);
        chk("oversize.ready_now", 32'(in_ready), 32'd0);
        chk_result("oversize", 1'b0, 1'b1, 0);
        pulse_start();
        nominal_stream();
        send(1'b0, -1);
        chk_result("after_oversize", 1'b1, 1'b0, 2);

        clear_log();
        pulse_start();
        nominal_stream();
        send(1'b1, 5);
        chk_result("gaps", 1'b1, 1'b0, 2);

        clear_log();
        pulse_start();
        nominal_stream();
        stream = stream[0:6];
        send(1'b0, -1);
        @(posedge clk);
        #1;
        chk("midrst.partial_writes", 32'(log_addr.size()), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst.busy",     32'(busy),     32'd0);
        chk("midrst.wr_en",    32'(wr_en),    32'd0);
        chk("midrst.wr_data",  wr_data,       32'd0);
        clear_log();
        pulse_start();
        nominal_stream();
        send(1'b0, -1);
        chk_result("after_rst", 1'b1, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
